// File: rtl/audio_pkg.sv
// Shared definitions for the microphone capture engine: default widths,
// FSM state encoding and the input-word slice helper.
package audio_pkg;

  localparam int unsigned ADDR_W_DEF   = 18;
  localparam int unsigned SAMPLE_W_DEF = 6;

  // Stored samples are the top SAMPLE_W bits of the 32-bit controller word.
  function automatic int unsigned sample_lsb(input int unsigned sample_w);
    return 32 - sample_w;
  endfunction

  localparam int unsigned SAMPLE_LSB = sample_lsb(SAMPLE_W_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FINISH  = 2'd2
  } state_e;

endpackage

// File: rtl/audio_capture_peak_meter.sv
// Peak magnitude tracker for kept samples; built only when
// AUDIO_CAPTURE_PEAK_EN is defined.
`ifdef AUDIO_CAPTURE_PEAK_EN
module capture_peak_meter
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-2:0] peak_o
);

  localparam logic [SAMPLE_W-2:0] MAG_MAX = '1;

  logic [SAMPLE_W-1:0] neg;
  logic [SAMPLE_W-2:0] mag;
  logic [SAMPLE_W-2:0] peak_q;

  // The most negative code has no positive twin, so it saturates to MAG_MAX.
  always_comb begin
    neg = ~sample_i + 1'b1;
    if (!sample_i[SAMPLE_W-1]) mag = sample_i[SAMPLE_W-2:0];
    else if (neg[SAMPLE_W-1])  mag = MAG_MAX;
    else                       mag = neg[SAMPLE_W-2:0];
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i)               peak_q <= '0;
    else if (valid_i && (mag > peak_q)) peak_q <= mag;
  end

  assign peak_o = peak_q;

endmodule
`endif

// File: rtl/audio_capture.sv
// Records a decimated, fixed-length microphone clip into sample RAM and keeps
// the controller FIFO drained otherwise. Optional peak port: AUDIO_CAPTURE_PEAK_EN.
module audio_capture
  import audio_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter int unsigned       SAMPLE_W  = SAMPLE_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       CLIP_LEN  = 16396,
  parameter int unsigned       DECIM     = 4
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                audio_in_available,
  input  logic [31:0]         left_channel_audio_in,
  output logic                read_audio_in,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_data,
  output logic                mem_wren,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   sample_count
`ifdef AUDIO_CAPTURE_PEAK_EN
  ,
  output logic [SAMPLE_W-2:0] peak
`endif
);

  localparam int unsigned       LSB      = sample_lsb(SAMPLE_W);
  localparam int unsigned       DW       = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0]     CNT_MAX  = DW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(CLIP_LEN - 1);

  state_e              state_q, state_d;
  logic [DW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                wren_q, wren_d;
  logic                stop_q, stop_d;

  logic [SAMPLE_W-1:0] sample_in;
  logic                keep;
  logic                last_write;
  logic                capture_start;
  logic                unused_lsbs;

  assign sample_in   = left_channel_audio_in[31:LSB];
  assign unused_lsbs = ^left_channel_audio_in[LSB-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    data_d        = data_q;
    wren_d        = 1'b0;
    stop_d        = stop_q;
    keep          = 1'b0;
    capture_start = 1'b0;
    last_write    = wren_q && (count_q == LAST_CNT);
    // Accepting in CAPTURE and draining elsewhere both pop every sample offered.
    read_audio_in = audio_in_available;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d       = CAPTURE;
          capture_start = 1'b1;
        end
      end
      CAPTURE: begin
        if (wren_q) begin
          count_d = count_q + 1'b1;
          if (!last_write) ptr_d = ptr_q + 1'b1;
        end
        if (audio_in_available) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        // No new keep once stopping or once the clip's final write is under way.
        keep = audio_in_available && (cnt_q == '0) && !stop_q && !last_write;
        if (keep) begin
          data_d = sample_in;
          wren_d = 1'b1;
        end
        if (stop) stop_d = 1'b1;
        if (last_write || ((stop || stop_q) && !keep)) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture_start) begin
      cnt_d   = '0;
      ptr_d   = BASE_ADDR;
      count_d = '0;
      stop_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= BASE_ADDR;
      count_q <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      stop_q  <= stop_d;
    end
  end

  assign mem_addr     = ptr_q;
  assign mem_data     = data_q;
  assign mem_wren     = wren_q;
  assign busy         = (state_q == CAPTURE);
  assign done         = (state_q == FINISH);
  assign sample_count = count_q;

`ifdef AUDIO_CAPTURE_PEAK_EN
  capture_peak_meter #(
    .SAMPLE_W (SAMPLE_W)
  ) u_peak (
    .clk      (CLOCK_50),
    .reset    (reset),
    .clear_i  (capture_start),
    .valid_i  (keep),
    .sample_i (sample_in),
    .peak_o   (peak)
  );
`endif

endmodule

// File: tb/tb_audio_capture.sv
// Directed bench for audio_capture: vector table for capture/drain/stop,
// hand sequences for decimation, mid-capture reset and the optional peak meter.
`timescale 1ns/1ps
module tb_audio_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stop, avail;
  logic [31:0] din;

  logic        rd1, wren1, busy1, done1;
  logic [17:0] addr1, cnt1;
  logic [5:0]  data1;
  logic        rd4, wren4, busy4, done4;
  logic [17:0] addr4, cnt4;
  logic [5:0]  data4;
`ifdef AUDIO_CAPTURE_PEAK_EN
  logic [4:0]  peak1, peak4;
`endif

  audio_capture #(.BASE_ADDR(18'd0), .CLIP_LEN(4), .DECIM(1)) u_dut1 (
    .CLOCK_50 (clk), .reset (reset), .start (start), .stop (stop),
    .audio_in_available (avail), .left_channel_audio_in (din),
    .read_audio_in (rd1), .mem_addr (addr1), .mem_data (data1), .mem_wren (wren1),
    .busy (busy1), .done (done1), .sample_count (cnt1)
`ifdef AUDIO_CAPTURE_PEAK_EN
    , .peak (peak1)
`endif
  );

  audio_capture #(.BASE_ADDR(18'd100), .CLIP_LEN(4), .DECIM(4)) u_dut4 (
    .CLOCK_50 (clk), .reset (reset), .start (start), .stop (stop),
    .audio_in_available (avail), .left_channel_audio_in (din),
    .read_audio_in (rd4), .mem_addr (addr4), .mem_data (data4), .mem_wren (wren4),
    .busy (busy4), .done (done4), .sample_count (cnt4)
`ifdef AUDIO_CAPTURE_PEAK_EN
    , .peak (peak4)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic w, input logic [17:0] a,
                      input logic [5:0] d, input logic b, input logic dn,
                      input logic [17:0] c);
    check({tag, " mem_wren"}, 32'(wren1), 32'(w));
    check({tag, " mem_addr"}, 32'(addr1), 32'(a));
    check({tag, " mem_data"}, 32'(data1), 32'(d));
    check({tag, " busy"},     32'(busy1), 32'(b));
    check({tag, " done"},     32'(done1), 32'(dn));
    check({tag, " count"},    32'(cnt1),  32'(c));
  endtask

  typedef struct {
    logic        start, stop, avail;
    logic [31:0] data;
    logic        e_read, e_wren;
    logic [17:0] e_addr;
    logic [5:0]  e_data;
    logic        e_busy, e_done;
    logic [17:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic sp, input logic av,
                              input logic [31:0] d, input logic r, input logic w,
                              input logic [17:0] a, input logic [5:0] dd,
                              input logic b, input logic dn, input logic [17:0] c);
    vec_t v;
    v.start = s;  v.stop = sp; v.avail = av; v.data = d;
    v.e_read = r; v.e_wren = w; v.e_addr = a; v.e_data = dd;
    v.e_busy = b; v.e_done = dn; v.e_cnt = c;
    return v;
  endfunction

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  vec_t vecs[$];

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; avail = 1'b0; din = 32'h0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [17:0] exp_cnt;
    logic        prev_w, exp_w;

    // Basic capture (DECIM=1, CLIP_LEN=4), idle drain, start+stop, stop on 3rd keep.
    vecs.push_back(mk(H,L,L,32'h0000_0000, L,L,18'd0,6'd0,  H,L,18'd0));
    vecs.push_back(mk(L,L,H,32'h0400_0000, H,H,18'd0,6'd1,  H,L,18'd0));
    vecs.push_back(mk(L,L,H,32'h0800_0000, H,H,18'd1,6'd2,  H,L,18'd1));
    vecs.push_back(mk(L,L,H,32'h0C00_0000, H,H,18'd2,6'd3,  H,L,18'd2));
    vecs.push_back(mk(L,L,H,32'h1000_0000, H,H,18'd3,6'd4,  H,L,18'd3));
    vecs.push_back(mk(L,L,H,32'h1400_0000, H,L,18'd3,6'd4,  L,H,18'd4));
    vecs.push_back(mk(L,L,L,32'h0000_0000, L,L,18'd3,6'd4,  L,L,18'd4));
    vecs.push_back(mk(L,L,H,32'h3C00_0000, H,L,18'd3,6'd4,  L,L,18'd4));
    vecs.push_back(mk(L,L,L,32'h0000_0000, L,L,18'd3,6'd4,  L,L,18'd4));
    vecs.push_back(mk(H,H,H,32'h2000_0000, H,L,18'd3,6'd4,  L,L,18'd4));
    vecs.push_back(mk(H,L,L,32'h0000_0000, L,L,18'd0,6'd4,  H,L,18'd0));
    vecs.push_back(mk(L,L,H,32'h2400_0000, H,H,18'd0,6'd9,  H,L,18'd0));
    vecs.push_back(mk(L,L,H,32'h2800_0000, H,H,18'd1,6'd10, H,L,18'd1));
    vecs.push_back(mk(L,H,H,32'h2C00_0000, H,H,18'd2,6'd11, H,L,18'd2));
    vecs.push_back(mk(L,L,H,32'h3000_0000, H,L,18'd3,6'd11, L,H,18'd3));
    vecs.push_back(mk(L,L,L,32'h0000_0000, L,L,18'd3,6'd11, L,L,18'd3));

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("reset", L, 18'd0, 6'd0, L, L, 18'd0);
    check("reset dut4 mem_addr", 32'(addr4), 32'd100);
    check("reset dut4 count", 32'(cnt4), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop;
      avail = vecs[i].avail; din  = vecs[i].data;
      #1;
      check($sformatf("v%0d read", i), 32'(rd1), 32'(vecs[i].e_read));
      @(negedge clk);
      chk1($sformatf("v%0d", i), vecs[i].e_wren, vecs[i].e_addr, vecs[i].e_data,
           vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt);
    end

    // Decimation: DECIM=4, BASE_ADDR=100, 16 back-to-back accepts.
    pulse_reset();
    start = 1'b1;
    @(negedge clk);
    check("dec busy", 32'(busy4), 32'd1);
    start = 1'b0;
    exp_cnt = '0;
    prev_w  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      avail = 1'b1;
      din   = 32'(i + 1) << 26;
      #1;
      check($sformatf("dec%0d read", i), 32'(rd4), 32'd1);
      @(negedge clk);
      if (prev_w) exp_cnt = exp_cnt + 18'd1;
      exp_w = ((i % 4) == 0) && (i <= 12);
      check($sformatf("dec%0d mem_wren", i), 32'(wren4), 32'(exp_w));
      if (exp_w) begin
        check($sformatf("dec%0d mem_addr", i), 32'(addr4), 32'(100 + i / 4));
        check($sformatf("dec%0d mem_data", i), 32'(data4), 32'(i + 1));
      end
      check($sformatf("dec%0d count", i), 32'(cnt4), 32'(exp_cnt));
      check($sformatf("dec%0d done", i), 32'(done4), 32'(i == 13));
      check($sformatf("dec%0d busy", i), 32'(busy4), 32'(i < 13));
      prev_w = exp_w;
    end
    avail = 1'b0;
    #1;
    check("dec read idle", 32'(rd4), 32'd0);

    // Reset after two writes drops the pending third write.
    pulse_reset();
    start = 1'b1;                            @(negedge clk);
    start = 1'b0; avail = 1'b1; din = 32'h0400_0000; @(negedge clk);
    din = 32'h0800_0000;                     @(negedge clk);
    avail = 1'b0;
    #1;
    check("rst read avail0", 32'(rd1), 32'd0);
    @(negedge clk);
    chk1("rst pre", L, 18'd2, 6'd2, H, L, 18'd2);
    reset = 1'b1; avail = 1'b1; din = 32'h0C00_0000;
    @(negedge clk);
    chk1("rst post", L, 18'd0, 6'd0, L, L, 18'd0);
    reset = 1'b0;
    #1;
    check("rst drain read", 32'(rd1), 32'd1);
    @(negedge clk);
    check("rst drain wren", 32'(wren1), 32'd0);
    avail = 1'b0; start = 1'b1;              @(negedge clk);
    start = 1'b0; avail = 1'b1; din = 32'h1C00_0000; @(negedge clk);
    chk1("rst restart", H, 18'd0, 6'd7, H, L, 18'd0);
    avail = 1'b0;
    @(negedge clk);

`ifdef AUDIO_CAPTURE_PEAK_EN
    begin
      logic [31:0] pk_words [4];
      logic [4:0]  pk_exp   [4];
      pk_words[0] = 32'h1400_0000; pk_exp[0] = 5'd5;
      pk_words[1] = 32'hB000_0000; pk_exp[1] = 5'd20;
      pk_words[2] = 32'h8000_0000; pk_exp[2] = 5'd31;
      pk_words[3] = 32'h3000_0000; pk_exp[3] = 5'd31;
      pulse_reset();
      start = 1'b1;
      @(negedge clk);
      check("peak cleared", 32'(peak1), 32'd0);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        avail = 1'b1;
        din   = pk_words[i];
        @(negedge clk);
        check($sformatf("peak%0d", i), 32'(peak1), 32'(pk_exp[i]));
      end
      idle_inputs();
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
